// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: data memory for the single-cycle RV32 datapath.
// The memory does lane-aligned byte, half and word stores on the rising edge.
// Loads are combinational and sign- or zero-extended.
// The block also keeps a sticky fault record and a committed-store counter.
module dmem_byte_lane #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] store_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_fault;
  logic [31:0]   r_faultAddr;
  logic [31:0]   r_storeCnt;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_inRange;
  logic          w_access;
  logic          w_misAligned;
  logic          w_misalign;
  logic          w_storeCommit;
  logic          w_loadOk;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_wrData;
  logic [31:0]   w_word;
  logic [31:0]   w_shifted;
  logic [31:0]   w_loadData;

  // The word index is taken from the offset relative to ADDR_BASE.
  // Any set bit above the RAM's index range marks the access as out of range.
  // This stops addresses past the end from aliasing back onto low words.
  assign w_off     = addr - ADDR_BASE;
  assign w_idx     = w_off[AW+1:2];
  assign w_inRange = (w_off[31:AW+2] == '0);
  assign w_access  = (mem_we | mem_re) & (mem_size != SIZE_NONE);

  // Check natural alignment for the requested access size.
  // Byte accesses can never be misaligned.
  always_comb begin
    w_misAligned = 1'b0;
    case (mem_size)
      SIZE_WORD: w_misAligned = (w_off[1:0] != 2'b00);
      SIZE_HALF: w_misAligned = w_off[0];
      default:   w_misAligned = 1'b0;
    endcase
  end

  assign w_misalign    = w_access & (w_misAligned | ~w_inRange);
  assign w_storeCommit = mem_we & (mem_size != SIZE_NONE) & ~w_misalign;
  assign w_loadOk      = mem_re & (mem_size != SIZE_NONE) & ~w_misalign;

  // Select the byte lanes to write.
  // The store data is replicated so that every candidate lane carries the right bits.
  always_comb begin
    w_byteEn = 4'b0000;
    w_wrData = wdata;
    case (mem_size)
      SIZE_WORD: begin
        w_byteEn = 4'b1111;
        w_wrData = wdata;
      end
      SIZE_HALF: begin
        w_byteEn = w_off[1] ? 4'b1100 : 4'b0011;
        w_wrData = {2{wdata[15:0]}};
      end
      SIZE_BYTE: begin
        w_byteEn = 4'b0001 << w_off[1:0];
        w_wrData = {4{wdata[7:0]}};
      end
      default: begin
        w_byteEn = 4'b0000;
        w_wrData = wdata;
      end
    endcase
  end

  // Write the enabled lanes of the RAM on the rising edge.
  // Gating with rst_n keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (w_storeCommit && rst_n) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (w_byteEn[lane]) begin
          r_mem[w_idx][lane*8 +: 8] <= w_wrData[lane*8 +: 8];
        end
      end
    end
  end

  // The combinational read shifts the addressed lane down to bit 0.
  // A store in the same cycle does not change this value until after the edge.
  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_off[1:0], 3'b000};

  // Extend the selected byte or half to 32 bits.
  // Return zero whenever no valid load is in progress.
  always_comb begin
    w_loadData = '0;
    if (w_loadOk) begin
      case (mem_size)
        SIZE_WORD: w_loadData = w_shifted;
        SIZE_HALF: w_loadData = {{16{~load_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        SIZE_BYTE: w_loadData = {{24{~load_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        default:   w_loadData = '0;
      endcase
    end
  end

  // Record only the first faulting address.
  // The flag stays set until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault     <= 1'b0;
      r_faultAddr <= '0;
    end else if (w_misalign && !r_fault) begin
      r_fault     <= 1'b1;
      r_faultAddr <= addr;
    end
  end

  // Count committed stores; the counter wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_storeCnt <= '0;
    end else if (w_storeCommit) begin
      r_storeCnt <= r_storeCnt + 32'd1;
    end
  end

  assign rdata      = w_loadData;
  assign misalign   = w_misalign;
  assign fault      = r_fault;
  assign fault_addr = r_faultAddr;
  assign store_cnt  = r_storeCnt;

endmodule

// File: tb/tb_dmem_byte_lane.sv
// tb_dmem_byte_lane: directed checks of dmem_byte_lane.
// Covers stores, loads, extension, faults, counter wrap and async reset.
module tb_dmem_byte_lane;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        misalign;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] store_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  dmem_byte_lane #(
    .DEPTH_WORDS(1024),
    .ADDR_BASE  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .misalign     (misalign),
    .fault        (fault),
    .fault_addr   (fault_addr),
    .store_cnt    (store_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access, then let the combinational outputs settle.
  task automatic applyStimulus(input logic we, input logic re, input logic [1:0] size,
                               input logic uns, input logic [31:0] a, input logic [31:0] d);
    mem_we        = we;
    mem_re        = re;
    mem_size      = size;
    load_unsigned = uns;
    addr          = a;
    wdata         = d;
    #1;
  endtask

  // Advance past the next rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 2'b11, 0, 32'h0, 32'h0);
    #12;
    checkOutput("reset_fault",      {31'd0, fault}, 32'd0);
    checkOutput("reset_fault_addr", fault_addr,     32'd0);
    checkOutput("reset_store_cnt",  store_cnt,      32'd0);
    rst_n = 1'b1;
    tick();

    // Word store followed by a word load
    applyStimulus(1, 0, W, 0, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_aligned_misalign", {31'd0, misalign}, 32'd0);
    tick();
    applyStimulus(0, 1, W, 0, 32'h10, 32'h0);
    checkOutput("lw_0x10",    rdata,          32'hDEADBEEF);
    checkOutput("cnt_after1", store_cnt,      32'd1);
    checkOutput("fault_clean", {31'd0, fault}, 32'd0);

    // Byte store merged into an existing word
    applyStimulus(1, 0, W, 0, 32'h20, 32'h11223344); tick();
    applyStimulus(1, 0, B, 0, 32'h21, 32'h000000AB); tick();
    applyStimulus(0, 1, W, 0, 32'h20, 32'h0);
    checkOutput("lw_0x20_merge", rdata, 32'h1122AB44);
    applyStimulus(0, 1, B, 0, 32'h21, 32'h0);
    checkOutput("lb_0x21",  rdata, 32'hFFFFFFAB);
    applyStimulus(0, 1, B, 1, 32'h21, 32'h0);
    checkOutput("lbu_0x21", rdata, 32'h000000AB);
    applyStimulus(0, 1, B, 0, 32'h23, 32'h0);
    checkOutput("lb_0x23",  rdata, 32'h00000011);
    checkOutput("cnt_after3", store_cnt, 32'd3);

    // Half store into the upper lanes
    applyStimulus(1, 0, W, 0, 32'h30, 32'h55667788); tick();
    applyStimulus(1, 0, H, 0, 32'h32, 32'h00008001); tick();
    applyStimulus(0, 1, H, 0, 32'h32, 32'h0);
    checkOutput("lh_0x32",  rdata, 32'hFFFF8001);
    applyStimulus(0, 1, H, 1, 32'h32, 32'h0);
    checkOutput("lhu_0x32", rdata, 32'h00008001);
    applyStimulus(0, 1, W, 0, 32'h30, 32'h0);
    checkOutput("lw_0x30",  rdata, 32'h80017788);
    applyStimulus(0, 1, H, 0, 32'h30, 32'h0);
    checkOutput("lh_0x30",  rdata, 32'h00007788);

    // Misaligned word store: flagged, suppressed and captured
    applyStimulus(1, 0, W, 0, 32'h40, 32'hCAFEF00D); tick();
    applyStimulus(1, 0, W, 0, 32'h41, 32'h12345678);
    checkOutput("sw_0x41_misalign", {31'd0, misalign}, 32'd1);
    tick();
    applyStimulus(0, 1, W, 0, 32'h40, 32'h0);
    checkOutput("fault_set",     {31'd0, fault}, 32'd1);
    checkOutput("fault_addr_41", fault_addr,     32'h41);
    checkOutput("cnt_no_inc",    store_cnt,      32'd6);
    checkOutput("lw_0x40_kept",  rdata,          32'hCAFEF00D);
    applyStimulus(0, 1, H, 0, 32'h43, 32'h0);
    checkOutput("lh_0x43_misalign", {31'd0, misalign}, 32'd1);
    checkOutput("lh_0x43_rdata",    rdata,             32'd0);
    tick();
    checkOutput("fault_addr_sticky", fault_addr, 32'h41);
    applyStimulus(0, 1, H, 0, 32'h42, 32'h0);
    checkOutput("lh_0x42", rdata, 32'hFFFFCAFE);

    // Out of range store must not alias onto word 0
    applyStimulus(1, 0, W, 0, 32'h0, 32'h0BADC0DE); tick();
    applyStimulus(1, 0, W, 0, 32'h1000, 32'hFFFFFFFF);
    checkOutput("sw_oor_misalign", {31'd0, misalign}, 32'd1);
    tick();
    applyStimulus(0, 1, W, 0, 32'h0, 32'h0);
    checkOutput("lw_0x0_no_alias", rdata,     32'h0BADC0DE);
    checkOutput("cnt_oor",         store_cnt, 32'd7);
    applyStimulus(0, 1, W, 0, 32'h1000, 32'h0);
    checkOutput("lw_oor_rdata", rdata, 32'd0);

    // Simultaneous load and store returns the pre-write value
    applyStimulus(1, 0, W, 0, 32'h50, 32'h5); tick();
    applyStimulus(1, 1, W, 0, 32'h50, 32'h7);
    checkOutput("rw_same_old", rdata, 32'h5);
    tick();
    applyStimulus(0, 1, W, 0, 32'h50, 32'h0);
    checkOutput("rw_same_new", rdata,     32'h7);
    checkOutput("cnt_after9",  store_cnt, 32'd9);

    // Counter wrap
    force dut.r_storeCnt = 32'hFFFFFFFF;
    #1;
    release dut.r_storeCnt;
    checkOutput("cnt_preset", store_cnt, 32'hFFFFFFFF);
    applyStimulus(1, 0, W, 0, 32'h60, 32'h1); tick();
    checkOutput("cnt_wrap", store_cnt, 32'd0);

    // Asynchronous reset mid-cycle while a store is pending
    applyStimulus(1, 0, W, 0, 32'h70, 32'h12345678); tick();
    applyStimulus(1, 0, W, 0, 32'h70, 32'h87654321);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_fault",      {31'd0, fault}, 32'd0);
    checkOutput("async_fault_addr", fault_addr,     32'd0);
    checkOutput("async_store_cnt",  store_cnt,      32'd0);
    tick();
    checkOutput("async_cnt_held", store_cnt, 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 1, W, 0, 32'h70, 32'h0);
    checkOutput("async_ram_kept", rdata, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
